// File: rtl/lutram_reader.sv
// lutram_reader: streams a base/len window of the LUTRAM onto a valid/ready port.
// Optional multi-pass replay is enabled with `define LUTRAM_READER_REPEAT_EN.
module lutram_reader #(
  parameter int BIT_DEPTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 784
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] len,
`ifdef LUTRAM_READER_REPEAT_EN
  input  logic [7:0]            repeat_count,
`endif
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [BIT_DEPTH-1:0]  rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BIT_DEPTH-1:0]  m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] DEP_A = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] TOP_A = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [ADDR_WIDTH-1:0] base_c;
  logic [ADDR_WIDTH-1:0] len_c;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  xfer;
  logic                  load;
  logic                  final_beat;

  assign rd_addr  = addr;
  assign base_c   = (base >= DEP_A) ? '0 : base;
  assign len_c    = (len > DEP_A) ? DEP_A : len;
  assign addr_nxt = (addr == TOP_A) ? '0 : addr + 1'b1;
  assign xfer     = m_valid && m_ready;
  assign load     = (state == RUN) && (remaining != '0)
                    && (!m_valid || m_ready);

`ifdef LUTRAM_READER_REPEAT_EN
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [7:0]            pass_q;
  logic                  wrap_pass;

  assign wrap_pass  = (remaining == 1) && (pass_q != '0);
  assign final_beat = (remaining == 1) && (pass_q == '0);
`else
  assign final_beat = (remaining == 1);
`endif

  // FIN behaves like IDLE for start so a new run can follow done directly
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef LUTRAM_READER_REPEAT_EN
      base_q    <= '0;
      len_q     <= '0;
      pass_q    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            addr      <= base_c;
            remaining <= len_c;
`ifdef LUTRAM_READER_REPEAT_EN
            base_q    <= base_c;
            len_q     <= len_c;
            pass_q    <= repeat_count;
`endif
            if (len_c == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (xfer) m_valid <= 1'b0;
          if (load) begin
            m_data  <= rd_data;
            m_valid <= 1'b1;
            m_last  <= final_beat;
`ifdef LUTRAM_READER_REPEAT_EN
            if (wrap_pass) begin
              addr      <= base_q;
              remaining <= len_q;
              pass_q    <= pass_q - 1'b1;
            end else begin
              addr      <= addr_nxt;
              remaining <= remaining - 1'b1;
            end
`else
            addr      <= addr_nxt;
            remaining <= remaining - 1'b1;
`endif
          end
          if (xfer && m_last) begin
            state   <= FIN;
            done    <= 1'b1;
            busy    <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lutram_reader.sv
// tb_lutram_reader: directed checks of lutram_reader against a LUTRAM model.
// The LUTRAM holds mem[a] = (3*a + 5) mod 256.
module tb_lutram_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] base;
  logic [9:0] len;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;
  logic       done;
`ifdef LUTRAM_READER_REPEAT_EN
  logic [7:0] repeat_count;
`endif

  int checks = 0;
  int errors = 0;
  int rp[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input int a);
    return 8'((a * 3 + 5) & 255);
  endfunction

  assign rd_data = mem(int'(rd_addr));

  lutram_reader dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
`ifdef LUTRAM_READER_REPEAT_EN
    .repeat_count(repeat_count),
`endif
    .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input int b, input int l);
    base  = 10'(b);
    len   = 10'(l);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // expects passes*l beats from window b..b+l-1 (mod 784)
  task automatic collect(input int b, input int l, input int passes,
                         input int limit, input int rs_at);
    int  n = 0;
    int  nlast = 0;
    bit  got_done = 0;
    int  total = l * passes;
    for (int cyc = 0; cyc < limit && !got_done; cyc++) begin
      if (done) begin
        got_done = 1;
        chk("busy_at_done", int'(busy), 0);
      end else begin
        m_ready = (cyc >= 1 && cyc - 1 < rp.size()) ? rp[cyc-1] : 1'b1;
        start = (cyc == rs_at);
        if (cyc == rs_at) begin
          base = 10'd500;
          len  = 10'd2;
        end
        if (m_valid) begin
          chk("beat_data", int'(m_data),
              int'(mem((b + (n % l)) % 784)));
          if (m_ready) begin
            chk("beat_last", int'(m_last), int'(n == total - 1));
            if (m_last) nlast++;
            n++;
          end
        end
        step();
        start = 1'b0;
      end
    end
    m_ready = 1'b1;
    chk("done_seen", int'(got_done), 1);
    chk("beat_count", n, total);
    chk("last_count", nlast, 1);
  endtask

  initial begin
    int exp1[4] = '{5, 8, 11, 14};
    rst = 1'b1; start = 1'b0; base = '0; len = '0; m_ready = 1'b1;
`ifdef LUTRAM_READER_REPEAT_EN
    repeat_count = '0;
`endif
    step(); step();
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(rd_addr), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_last", int'(m_last), 0);
    rst = 1'b0;
    step();

    // basic run with exact cycle timing
    start_cmd(0, 4);
    chk("t1_busy", int'(busy), 1);
    chk("t1_valid0", int'(m_valid), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_valid", int'(m_valid), 1);
      chk("t1_data", int'(m_data), exp1[k]);
      chk("t1_last", int'(m_last), int'(k == 3));
    end
    step();
    chk("t1_done", int'(done), 1);
    chk("t1_busy_end", int'(busy), 0);
    chk("t1_valid_end", int'(m_valid), 0);

    // wrap-around, started in the done cycle
    start_cmd(782, 4);
    step();
    chk("wrap_b0", int'(m_data), 47);
    step();
    chk("wrap_b1", int'(m_data), 50);
    step();
    chk("wrap_b2", int'(m_data), 5);
    step();
    chk("wrap_b3", int'(m_data), 8);
    chk("wrap_last", int'(m_last), 1);
    step();
    chk("wrap_done", int'(done), 1);
    step();

    // backpressure 1,0,0,1,1
    rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    start_cmd(100, 3);
    collect(100, 3, 1, 40, -1);
    rp = '{};
    step();

    // zero length
    start_cmd(0, 0);
    chk("len0_done", int'(done), 1);
    chk("len0_valid", int'(m_valid), 0);
    chk("len0_busy", int'(busy), 0);
    step();
    chk("len0_done_off", int'(done), 0);
    chk("len0_valid2", int'(m_valid), 0);

    // oversize length clamps to 784
    start_cmd(0, 900);
    collect(0, 784, 1, 900, -1);
    step();

    // oversize base latches as 0
    start_cmd(1000, 2);
    collect(0, 2, 1, 20, -1);
    step();

    // start while busy is ignored
    start_cmd(0, 4);
    collect(0, 4, 1, 20, 2);
    step();

    // reset mid-run after two transfers
    start_cmd(0, 10);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", int'(m_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_addr", int'(rd_addr), 0);
    chk("mid_rst_last", int'(m_last), 0);
    step(); step();
    chk("mid_rst_idle", int'(m_valid), 0);
    start_cmd(5, 3);
    collect(5, 3, 1, 20, -1);
    step();

`ifdef LUTRAM_READER_REPEAT_EN
    repeat_count = 8'd2;
    start_cmd(10, 2);
    collect(10, 2, 3, 30, -1);
    repeat_count = '0;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
